load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU. Takes the ALU result as the effective address plus rs2 store
//  data and drives a request/grant/response data-memory bus. Returns sign/zero-extended load data to writeback.
//  Multi-cycle: it stalls execute via ex_ready while an access is in flight. One access outstanding at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in REQ+WAIT before the access is abandoned with wb_err (must be >= 2)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  ex_valid     in   1   execute presents a memory op this cycle
//  ex_ready     out  1   LSU can accept; high only in IDLE
//  mem_read     in   1   op is a load
//  mem_write    in   1   op is a store
//  funct3       in   3   RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  alu_out      in   32  effective address from ALU
//  store_data   in   32  rs2 value, unaligned (data in low lanes)
//  dmem_req     out  1   bus request, held until dmem_gnt
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_gnt     in   1   request accepted this cycle
//  dmem_rvalid  in   1   response (read data or write ack)
//  dmem_rdata   in   32  read data, valid with dmem_rvalid
//  wb_valid     out  1   one-cycle completion pulse
//  wb_data      out  32  extended load data; 0 for stores/errors
//  wb_err       out  1   with wb_valid: illegal funct3, timeout, or misalign (if enabled)
// BEHAVIOUR
//  Reset: state IDLE; ex_ready=1; dmem_req/dmem_we/wb_valid/wb_err=0; dmem_addr/be/wdata/wb_data=0; timer=0.
//  FSM IDLE->REQ->WAIT->DONE->IDLE. Accept = ex_valid & ex_ready & (mem_read|mem_write); latch op, funct3, addr, data.
//  IDLE: on accept go REQ (dmem_req=1 from next cycle). mem_read&mem_write both 1, or funct3 illegal for the op
//   (load 011/110/111; store >=011): no bus cycle, go DONE with err=1.
//  REQ: dmem_req held stable until dmem_gnt; on gnt drop req next cycle, go WAIT. gnt and rvalid same cycle: -> DONE.
//  WAIT: on dmem_rvalid capture extended data, go DONE. DONE: wb_valid=1 one cycle, then IDLE (ex_ready back next cycle).
//  Min latency accept->wb_valid: 3 cycles (gnt on first req cycle, rvalid next cycle).
//  Store lanes: SB be=4'b0001<<a[1:0], wdata={4{d[7:0]}}; SH be=4'b0011<<{a[1],1'b0}, wdata={2{d[15:0]}}; SW be=4'hF.
//  Loads: select lane by latched a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough. Loads drive be per width.
//  Timer: counts every cycle in REQ/WAIT; at TIMEOUT_CYCLES-1 drop req, go DONE with err=1; any later rvalid in IDLE ignored.
//  Reset mid-access: immediate IDLE, req drops next edge, pending response discarded, no wb_valid.
//  ex_valid with neither mem_read nor mem_write: ignored, ex_ready stays 1.
// CONFIGURATION
//  `MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 -> no bus cycle, DONE with wb_err=1.
//  Not defined: low address bits below access width are forced to 0 (natural alignment) and access proceeds normally.
// STRUCTURE
//  lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), lsu_state_t enum {IDLE,REQ,WAIT,DONE}, lane/be helper functions.
//  Sub-module lsu_align (combinational): store be/wdata generation and load lane select + extension.
// TESTING
//  1 SW addr=0x100 data=0xDEADBEEF, gnt cycle1, rvalid cycle2 -> be=F, wdata=0xDEADBEEF, wb_valid at cycle3, err=0.
//  2 SB addr=0x103 data=0x000000A5 -> be=4'b1000, wdata=0xA5A5A5A5; LB same addr, rdata=0x80112233 -> wb_data=0xFFFFFF80.
//  3 LHU addr=0x202, rdata=0x8001_1234 -> wb_data=0x00008001; LH same -> 0xFFFF8001.
//  4 dmem_gnt withheld 5 cycles: req/addr/be stable; then no rvalid -> wb_err pulse exactly TIMEOUT_CYCLES after entering REQ.
//  5 LW addr=0x102: with MISALIGN_TRAP_EN wb_err, no dmem_req; without it dmem_addr=0x100, normal load.
//  6 rst asserted in WAIT -> next cycle IDLE, ex_ready=1, late rvalid produces no wb_valid; funct3=3'b111 load -> wb_err.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states and
// byte-lane helpers used by both the top level and the alignment datapath.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] natural_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane datapath: store byte enables / lane-replicated write data,
// and load lane selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  acc_size,
    input  logic [1:0]  acc_offset,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign be = lane_be(acc_size, acc_offset);

    // Replicate the low store bytes across every lane; the enables pick the real one
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[gi*8 +: 8] = (acc_size == 2'b00) ? store_data[7:0] :
                                      (acc_size == 2'b01) ? store_data[(gi%2)*8 +: 8] :
                                                            store_data[gi*8 +: 8];
        end
    endgenerate

    assign shifted = rdata >> {ld_offset, 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (ld_funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = shifted;
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit with one outstanding req/gnt/rvalid bus access and a timeout.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses error out instead of being force-aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    lsu_state_t    state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          is_store_reg, is_store_next;
    logic [2:0]    funct3_reg, funct3_next;
    logic [1:0]    offset_reg, offset_next;
    logic [31:0]   addr_reg, addr_next;
    logic [3:0]    be_reg, be_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [31:0]   wb_data_reg, wb_data_next;
    logic          wb_err_reg, wb_err_next;

    logic          accept;
    logic          bad_op;
    logic [1:0]    req_offset;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic [31:0]   load_data;

    assign accept     = ex_valid && (state_reg == IDLE) && (mem_read || mem_write);
    assign req_offset = natural_offset(funct3[1:0], alu_out[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign bad_op = (mem_read && mem_write) || !funct3_legal(mem_write, funct3) ||
                    is_misaligned(funct3[1:0], alu_out[1:0]);
`else
    assign bad_op = (mem_read && mem_write) || !funct3_legal(mem_write, funct3);
`endif

    lsu_align u_align (
        .acc_size   (funct3[1:0]),
        .acc_offset (req_offset),
        .store_data (store_data),
        .be         (be_new),
        .wdata      (wdata_new),
        .ld_funct3  (funct3_reg),
        .ld_offset  (offset_reg),
        .rdata      (dmem_rdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        is_store_next = is_store_reg;
        funct3_next   = funct3_reg;
        offset_next   = offset_reg;
        addr_next     = addr_reg;
        be_next       = be_reg;
        wdata_next    = wdata_reg;
        wb_data_next  = wb_data_reg;
        wb_err_next   = wb_err_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    timer_next    = '0;
                    is_store_next = mem_write;
                    funct3_next   = funct3;
                    offset_next   = req_offset;
                    addr_next     = {alu_out[31:2], 2'b00};
                    be_next       = be_new;
                    wdata_next    = wdata_new;
                    wb_data_next  = 32'h0;
                    wb_err_next   = bad_op;
                    state_next    = bad_op ? DONE : REQ;
                end
            end
            REQ: begin
                timer_next = timer_reg + TW'(1);
                // A response arriving with the grant completes the access; otherwise timeout wins
                if (dmem_gnt && dmem_rvalid) begin
                    wb_data_next = is_store_reg ? 32'h0 : load_data;
                    state_next   = DONE;
                end else if (timer_reg == TIMER_LAST) begin
                    wb_err_next = 1'b1;
                    state_next  = DONE;
                end else if (dmem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                timer_next = timer_reg + TW'(1);
                if (dmem_rvalid) begin
                    wb_data_next = is_store_reg ? 32'h0 : load_data;
                    state_next   = DONE;
                end else if (timer_reg == TIMER_LAST) begin
                    wb_err_next = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            is_store_reg <= 1'b0;
            funct3_reg   <= 3'b000;
            offset_reg   <= 2'b00;
            addr_reg     <= 32'h0;
            be_reg       <= 4'h0;
            wdata_reg    <= 32'h0;
            wb_data_reg  <= 32'h0;
            wb_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            is_store_reg <= is_store_next;
            funct3_reg   <= funct3_next;
            offset_reg   <= offset_next;
            addr_reg     <= addr_next;
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            wb_data_reg  <= wb_data_next;
            wb_err_reg   <= wb_err_next;
        end
    end

    assign ex_ready   = (state_reg == IDLE);
    assign dmem_req   = (state_reg == REQ);
    assign dmem_we    = (state_reg == REQ) && is_store_reg;
    assign dmem_addr  = addr_reg;
    assign dmem_be    = be_reg;
    assign dmem_wdata = wdata_reg;
    assign wb_valid   = (state_reg == DONE);
    assign wb_data    = wb_data_reg;
    assign wb_err     = (state_reg == DONE) && wb_err_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: aligned/byte/half accesses,
// grant stall with timeout, misaligned word load, mid-access reset and illegal ops.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        wb_err;

    int check_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .alu_out     (alu_out),
        .store_data  (store_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .wb_err      (wb_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Presents one op for a single cycle; returns in the first cycle after the accept edge
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        check("ready_before_issue", 32'(ex_ready), 32'd1);
        ex_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_out    = addr;
        store_data = data;
        @(negedge clk);
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic bus_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                          input int gnt_wait, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb);
        issue(rd, wr, f3, addr, data);
        for (int i = 0; i <= gnt_wait; i++) begin
            check({tag, ".req"}, 32'(dmem_req), 32'd1);
            check({tag, ".ready"}, 32'(ex_ready), 32'd0);
            check({tag, ".we"}, 32'(dmem_we), 32'(wr));
            check({tag, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
            check({tag, ".be"}, 32'(dmem_be), 32'(exp_be));
            if (wr) check({tag, ".wdata"}, dmem_wdata, exp_wdata);
            if (i == gnt_wait) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        check({tag, ".req_drop"}, 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, ".wb_err"}, 32'(wb_err), 32'd0);
        check({tag, ".wb_data"}, wb_data, exp_wb);
        @(negedge clk);
        check({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
        check({tag, ".ready_after"}, 32'(ex_ready), 32'd1);
        $display("op %-8s addr=0x%08h be=%b wb_data=0x%08h", tag, addr, exp_be, exp_wb);
    endtask

    task automatic err_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
        issue(rd, wr, f3, addr, 32'h0);
        check({tag, ".no_req"}, 32'(dmem_req), 32'd0);
        check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, ".wb_err"}, 32'(wb_err), 32'd1);
        check({tag, ".wb_data"}, wb_data, 32'h0);
        @(negedge clk);
        check({tag, ".wb_pulse"}, 32'(wb_valid), 32'd0);
        check({tag, ".ready_after"}, 32'(ex_ready), 32'd1);
        $display("op %-8s addr=0x%08h error completion", tag, addr);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst.ex_ready", 32'(ex_ready), 32'd1);
        check("rst.req", 32'(dmem_req), 32'd0);
        check("rst.we", 32'(dmem_we), 32'd0);
        check("rst.wb_valid", 32'(wb_valid), 32'd0);
        check("rst.wb_err", 32'(wb_err), 32'd0);
        check("rst.addr", dmem_addr, 32'h0);
        check("rst.be", 32'(dmem_be), 32'd0);
        check("rst.wdata", dmem_wdata, 32'h0);
        check("rst.wb_data", wb_data, 32'h0);
        $display("op reset   state checked");
        rst = 1'b0;

        bus_op("sw",  1'b0, 1'b1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 4'hF,    32'hDEADBEEF, 32'h0);
        bus_op("sb",  1'b0, 1'b1, F3_B,  32'h103, 32'h000000A5, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0);
        bus_op("lb",  1'b1, 1'b0, F3_B,  32'h103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
        bus_op("lhu", 1'b1, 1'b0, F3_HU, 32'h202, 32'h0,        32'h80011234, 1, 4'b1100, 32'h0,        32'h00008001);
        bus_op("lh",  1'b1, 1'b0, F3_H,  32'h202, 32'h0,        32'h80011234, 2, 4'b1100, 32'h0,        32'hFFFF8001);
        bus_op("sh",  1'b0, 1'b1, F3_H,  32'h102, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0);
        bus_op("lbu", 1'b1, 1'b0, F3_BU, 32'h101, 32'h0,        32'h80112233, 0, 4'b0010, 32'h0,        32'h00000022);

        // Grant withheld 5 cycles, then no response: timeout after TO cycles in REQ/WAIT
        issue(1'b1, 1'b0, F3_W, 32'h300, 32'h0);
        k = 1;
        for (int i = 0; i < 5; i++) begin
            check("to.req_hold", 32'(dmem_req), 32'd1);
            check("to.addr_hold", dmem_addr, 32'h300);
            check("to.be_hold", 32'(dmem_be), 32'hF);
            @(negedge clk);
            k++;
        end
        check("to.req_hold", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        k++;
        while (!wb_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("to.latency", 32'(k), 32'(TO + 1));
        check("to.wb_err", 32'(wb_err), 32'd1);
        check("to.wb_data", wb_data, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55AA55AA;
        check("to.wb_pulse", 32'(wb_valid), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("to.late_rvalid", 32'(wb_valid), 32'd0);
        check("to.ready_after", 32'(ex_ready), 32'd1);
        $display("op timeout wb after %0d cycles", k);

`ifdef MISALIGN_TRAP_EN
        err_op("lw_mis", 1'b1, 1'b0, F3_W, 32'h102);
`else
        bus_op("lw_mis", 1'b1, 1'b0, F3_W, 32'h102, 32'h0, 32'hCAFEF00D, 0, 4'hF, 32'h0, 32'hCAFEF00D);
`endif

        // Reset while waiting for the response
        issue(1'b1, 1'b0, F3_W, 32'h400, 32'h0);
        check("rstw.req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rstw.in_wait", 32'(dmem_req), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw.ready", 32'(ex_ready), 32'd1);
        check("rstw.req", 32'(dmem_req), 32'd0);
        check("rstw.wb_valid", 32'(wb_valid), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("rstw.late_rvalid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        check("rstw.quiet", 32'(wb_valid), 32'd0);
        $display("op rst_wait response discarded");

        err_op("ld_f111", 1'b1, 1'b0, 3'b111, 32'h500);
        err_op("st_f011", 1'b0, 1'b1, 3'b011, 32'h504);
        err_op("rd_wr",   1'b1, 1'b1, F3_W,   32'h508);

        // ex_valid without a memory op is not accepted
        @(negedge clk);
        ex_valid = 1'b1;
        funct3   = F3_W;
        alu_out  = 32'h600;
        @(negedge clk);
        ex_valid = 1'b0;
        check("nop.ready", 32'(ex_ready), 32'd1);
        check("nop.req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("nop.wb_valid", 32'(wb_valid), 32'd0);
        $display("op nop     ignored");

        $display("%0d/%0d checks passed", check_count - fail_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
